// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback
// sequencing for lw, sw, R-type, beq, addi and j with a bounded memory wait.
module mips_multicycle_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic [1:0] PCSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       illegal_op,
   output logic       bus_err,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
      S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             bus_err_q;
   logic             wait_st, expired;

   // Wait-state detection and memory timeout; mem_ready on the expiry cycle wins.
   always_comb begin
      wait_st = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
      expired = (TIMEOUT != 0) && wait_st && !mem_ready &&
                (cnt == CNT_W'(TIMEOUT - 1));
   end

   // Next-state and wait-counter computation.
   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:   if (!expired && mem_ready) state_next = S_DECODE;
                    else                       state_next = S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYP:      state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR:  if (Op == OP_SW) state_next = S_MEMWR;
                    else             state_next = S_MEMRD;
         S_MEMRD:   if (expired)        state_next = S_FETCH;
                    else if (mem_ready) state_next = S_MEMWB;
                    else                state_next = S_MEMRD;
         S_MEMWR:   if (expired || mem_ready) state_next = S_FETCH;
                    else                      state_next = S_MEMWR;
         S_EXECUTE: state_next = S_ALUWB;
         S_ADDIEX:  state_next = S_ADDIWB;
         default:   state_next = S_FETCH;
      endcase
      // A timeout re-entering FETCH counts as a fresh entry, so the counter restarts.
      if (!wait_st || mem_ready || expired || (state_next != state)) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // State, wait counter and sticky bus error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         cnt       <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (expired) bus_err_q <= 1'b1;
         else         bus_err_q <= bus_err_q;
      end
   end

   // Per-state control decode; reset forces every output low.
   always_comb begin
      {IorD, IRWrite, MemWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
       ALUOp, RegDst, MemtoReg, RegWrite, illegal_op} = 16'b0;
      if (reset) begin
         bus_err   = 1'b0;
         state_dbg = 4'd0;
      end else begin
         bus_err   = bus_err_q;
         state_dbg = state;
         case (state)
            S_FETCH: begin
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               case (Op)
                  OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                  default:                                      illegal_op = 1'b1;
               endcase
            end
            S_MEMADR, S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMRD:  IorD = 1'b1;
            S_MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            S_MEMWR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
            end
            S_EXECUTE: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            S_ALUWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b01;
               PCSrc   = 2'b01;
               Branch  = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
               PCSrc   = 2'b10;
               PCWrite = 1'b1;
            end
            default: state_dbg = state;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with TIMEOUT=4; expected control words are hand-derived.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op;
   logic       mem_ready;
   logic       IorD, IRWrite, MemWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite;
   logic       illegal_op, bus_err;
   logic [1:0] PCSrc, ALUSrcB, ALUOp;
   logic [3:0] state_dbg;

   int checks = 0;
   int errors = 0;

   mips_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
      .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
      .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .illegal_op(illegal_op), .bus_err(bus_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Field order: IorD IRWrite MemWrite PCWrite Branch PCSrc ALUSrcA ALUSrcB ALUOp RegDst MemtoReg RegWrite illegal_op bus_err
   localparam logic [16:0] C_ZERO = 17'b0_0_0_0_0_00_0_00_00_0_0_0_0_0;
   localparam logic [16:0] C_F1   = 17'b0_1_0_1_0_00_0_01_00_0_0_0_0_0;
   localparam logic [16:0] C_F0   = 17'b0_0_0_0_0_00_0_01_00_0_0_0_0_0;
   localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_00_0_11_00_0_0_0_0_0;
   localparam logic [16:0] C_ILL  = 17'b0_0_0_0_0_00_0_11_00_0_0_0_1_0;
   localparam logic [16:0] C_MADR = 17'b0_0_0_0_0_00_1_10_00_0_0_0_0_0;
   localparam logic [16:0] C_MRD  = 17'b1_0_0_0_0_00_0_00_00_0_0_0_0_0;
   localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_00_0_00_00_0_1_1_0_0;
   localparam logic [16:0] C_MWR  = 17'b1_0_1_0_0_00_0_00_00_0_0_0_0_0;
   localparam logic [16:0] C_EXE  = 17'b0_0_0_0_0_00_1_00_10_0_0_0_0_0;
   localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_00_0_00_00_1_0_1_0_0;
   localparam logic [16:0] C_BR   = 17'b0_0_0_0_1_01_1_00_01_0_0_0_0_0;
   localparam logic [16:0] C_IWB  = 17'b0_0_0_0_0_00_0_00_00_0_0_1_0_0;
   localparam logic [16:0] C_JMP  = 17'b0_0_0_1_0_10_0_00_00_0_0_0_0_0;
   localparam logic [16:0] C_BE   = 17'b0_0_0_0_0_00_0_00_00_0_0_0_0_1;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

   logic [16:0] ctrl;
   assign ctrl = {IorD, IRWrite, MemWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
                  ALUOp, RegDst, MemtoReg, RegWrite, illegal_op, bus_err};

   // Apply inputs on the falling edge, check 1 time unit later, well away from the rising edge.
   task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                       input logic [3:0] es, input logic [16:0] ec, input string tag);
      @(negedge clk);
      reset     = rst;
      Op        = op;
      mem_ready = mr;
      #1;
      checks++;
      assert (state_dbg === es) else begin
         errors++;
         $error("FAIL %s state: observed %0d expected %0d", tag, state_dbg, es);
      end
      checks++;
      assert (ctrl === ec) else begin
         errors++;
         $error("FAIL %s ctrl: observed %b expected %b", tag, ctrl, ec);
      end
   endtask

   initial begin
      reset = 1'b1; Op = RT; mem_ready = 1'b1;
      // reset held 3 cycles with mem_ready high
      step(1'b1, RT, 1'b1, 4'd0, C_ZERO, "rst0");
      step(1'b1, RT, 1'b1, 4'd0, C_ZERO, "rst1");
      step(1'b1, RT, 1'b1, 4'd0, C_ZERO, "rst2");
      // R-type
      step(1'b0, RT, 1'b1, 4'd0, C_F1,  "r_fetch");
      step(1'b0, RT, 1'b1, 4'd1, C_DEC, "r_dec");
      step(1'b0, RT, 1'b1, 4'd6, C_EXE, "r_exe");
      step(1'b0, RT, 1'b1, 4'd7, C_AWB, "r_wb");
      // lw with 3 wait cycles; the 4th MEMRD cycle coincides with expiry and mem_ready wins
      step(1'b0, LW, 1'b1, 4'd0, C_F1,   "lw_fetch");
      step(1'b0, LW, 1'b1, 4'd1, C_DEC,  "lw_dec");
      step(1'b0, LW, 1'b1, 4'd2, C_MADR, "lw_adr");
      step(1'b0, LW, 1'b0, 4'd3, C_MRD,  "lw_rd0");
      step(1'b0, LW, 1'b0, 4'd3, C_MRD,  "lw_rd1");
      step(1'b0, LW, 1'b0, 4'd3, C_MRD,  "lw_rd2");
      step(1'b0, LW, 1'b1, 4'd3, C_MRD,  "lw_rd3");
      step(1'b0, LW, 1'b1, 4'd4, C_MWB,  "lw_wb");
      // sw never accepted: MemWrite for 4 cycles then bus_err and back to FETCH
      step(1'b0, SW, 1'b1, 4'd0, C_F1,   "sw_fetch");
      step(1'b0, SW, 1'b1, 4'd1, C_DEC,  "sw_dec");
      step(1'b0, SW, 1'b1, 4'd2, C_MADR, "sw_adr");
      step(1'b0, SW, 1'b0, 4'd5, C_MWR,  "sw_wr0");
      step(1'b0, SW, 1'b0, 4'd5, C_MWR,  "sw_wr1");
      step(1'b0, SW, 1'b0, 4'd5, C_MWR,  "sw_wr2");
      step(1'b0, SW, 1'b0, 4'd5, C_MWR,  "sw_wr3");
      step(1'b0, SW, 1'b0, 4'd0, C_F0 | C_BE, "sw_to_fetch");
      // illegal opcode, with bus_err still sticky
      step(1'b0, BAD, 1'b1, 4'd0, C_F1 | C_BE,  "ill_fetch");
      step(1'b0, BAD, 1'b1, 4'd1, C_ILL | C_BE, "ill_dec");
      // beq
      step(1'b0, BEQ, 1'b1, 4'd0, C_F1 | C_BE,  "beq_fetch");
      step(1'b0, BEQ, 1'b1, 4'd1, C_DEC | C_BE, "beq_dec");
      step(1'b0, BEQ, 1'b1, 4'd8, C_BR | C_BE,  "beq_br");
      // j
      step(1'b0, JMP, 1'b1, 4'd0, C_F1 | C_BE,  "j_fetch");
      step(1'b0, JMP, 1'b1, 4'd1, C_DEC | C_BE, "j_dec");
      step(1'b0, JMP, 1'b1, 4'd11, C_JMP | C_BE, "j_jump");
      // addi
      step(1'b0, ADDI, 1'b1, 4'd0, C_F1 | C_BE,   "addi_fetch");
      step(1'b0, ADDI, 1'b1, 4'd1, C_DEC | C_BE,  "addi_dec");
      step(1'b0, ADDI, 1'b1, 4'd9, C_MADR | C_BE, "addi_ex");
      step(1'b0, ADDI, 1'b1, 4'd10, C_IWB | C_BE, "addi_wb");
      // reset in MEMWR after the counter has advanced
      step(1'b0, SW, 1'b1, 4'd0, C_F1 | C_BE,   "sw2_fetch");
      step(1'b0, SW, 1'b1, 4'd1, C_DEC | C_BE,  "sw2_dec");
      step(1'b0, SW, 1'b1, 4'd2, C_MADR | C_BE, "sw2_adr");
      step(1'b0, SW, 1'b0, 4'd5, C_MWR | C_BE,  "sw2_wr0");
      step(1'b0, SW, 1'b0, 4'd5, C_MWR | C_BE,  "sw2_wr1");
      step(1'b1, SW, 1'b0, 4'd0, C_ZERO,        "sw2_rst");
      // counter restarted at 0: FETCH times out only on its 4th stalled cycle
      step(1'b0, SW, 1'b0, 4'd0, C_F0, "post_rst0");
      step(1'b0, SW, 1'b0, 4'd0, C_F0, "post_rst1");
      step(1'b0, SW, 1'b0, 4'd0, C_F0, "post_rst2");
      step(1'b0, SW, 1'b0, 4'd0, C_F0, "post_rst3");
      step(1'b0, SW, 1'b0, 4'd0, C_F0 | C_BE, "fetch_timeout");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
